// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the RAM port arbiter.
//   arb_state_t  : arbiter FSM state (IDLE, ISSUE, WAIT, RESP), 2 bits
//   REQ_*        : conventional requester slot assignments
//   MAX_NREQ     : largest supported requester count
//   idx_width()  : width of a requester index (at least 1 bit)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int REQ_LOADER = 0;
    localparam int REQ_DATA   = 1;
    localparam int REQ_FETCH  = 2;

    localparam int MAX_NREQ = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side handshake plus RAM pin bundle.
//   req_valid/req_we/req_addr/req_wdata : per-requester request, packed by index
//   req_ack/rsp_rdata                   : completion pulse and read data
//   mem_addr/mem_wdata/mem_wren/mem_q   : single-port RAM pins
// Handshake: a requester raises req_valid with stable we/addr/wdata and holds
// them until it samples its req_ack bit high; req_ack is a one-cycle pulse and
// rsp_rdata is meaningful only while that pulse is high.
// Modports: master = requesters + RAM (drive requests and mem_q),
//           slave  = the arbiter.
interface mem_port_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ack;
    logic [DATA_W-1:0]      rsp_rdata;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_wren;
    logic [DATA_W-1:0]      mem_q;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_q,
        input  req_ack, rsp_rdata, mem_addr, mem_wdata, mem_wren
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_q,
        output req_ack, rsp_rdata, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req : request vector (N bits)
//   ptr : highest-priority index (must be < N)
//   any : at least one request set
//   idx : first set request at or above ptr, wrapping modulo N
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);
    logic [N-1:0] rot;

    always_comb begin
        // Doubling the vector makes the right-rotate by ptr a plain shift;
        // bit k of rot then corresponds to requester (ptr + k) mod N.
        rot = N'({req, req} >> ptr);
        any = |req;
        idx = '0;
        // Descending scan so the lowest rotated position wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) idx = IW'((32'(ptr) + k) % N);
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of a single-port RAM shared by NREQ
// requesters, one transaction in flight at a time.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : requester handshake and RAM pins
//   busy        : transaction in progress (state != IDLE)
//   gnt_id      : index of the current or most recent winner
//   dbg_state   : FSM state
//   dbg_rr_ptr  : current round-robin priority pointer
// Flow: IDLE arbitrates and latches the winner; ISSUE drives the RAM for one
// cycle (the only cycle write enable can be high); reads then sit in WAIT for
// READ_LAT cycles counted from the address cycle; RESP pulses the winner's ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    localparam int IDX_W   = idx_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic [IDX_W-1:0]  gnt_id,
    output arb_state_t        dbg_state,
    output logic [IDX_W-1:0]  dbg_rr_ptr
);
    localparam int CNT_W = 2;

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  win;
    logic              we_l;
    logic [CNT_W-1:0]  wait_cnt;

    logic [NREQ-1:0]   ack_r;
    logic [DATA_W-1:0] rdata_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              wren_r;
    logic              busy_r;
    logic [IDX_W-1:0]  gnt_r;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;

    rr_pick #(
        .N  (NREQ),
        .IW (IDX_W)
    ) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            win      <= '0;
            we_l     <= 1'b0;
            wait_cnt <= '0;
            ack_r    <= '0;
            rdata_r  <= '0;
            addr_r   <= '0;
            wdata_r  <= '0;
            wren_r   <= 1'b0;
            busy_r   <= 1'b0;
            gnt_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        // The RAM address/data registers double as the latched
                        // transaction; they are held until the next grant.
                        win     <= pick_idx;
                        gnt_r   <= pick_idx;
                        we_l    <= bus.req_we[pick_idx];
                        addr_r  <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
                        wdata_r <= bus.req_wdata[pick_idx*DATA_W +: DATA_W];
                        wren_r  <= bus.req_we[pick_idx];
                        busy_r  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    wren_r <= 1'b0;
                    if (we_l) begin
                        ack_r <= NREQ'(1) << win;
                        state <= RESP;
                    end else begin
                        wait_cnt <= CNT_W'(READ_LAT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rdata_r <= bus.mem_q;
                        ack_r   <= NREQ'(1) << win;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    ack_r  <= '0;
                    rr_ptr <= (win == IDX_W'(NREQ - 1)) ? '0 : win + 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ack   = ack_r;
    assign bus.rsp_rdata = rdata_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.mem_wren  = wren_r;
    assign busy          = busy_r;
    assign gnt_id        = gnt_r;
    assign dbg_state     = state;
    assign dbg_rr_ptr    = rr_ptr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// Two instances: dut_a (READ_LAT=1) carries most scenarios, dut_b (READ_LAT=3)
// checks read latency. A shared request driver is steered to one of them by
// sel_b. Expected acks are queued when requests are issued and a negedge
// monitor pops and compares them as acks appear.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 2;
    localparam int EW     = NREQ + 1 + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // ---------------- request driver signals ----------------
    logic                   sel_b   = 1'b0;
    logic [NREQ-1:0]        r_valid = '0;
    logic [NREQ-1:0]        r_we    = '0;
    logic [NREQ*ADDR_W-1:0] r_addr  = '0;
    logic [NREQ*DATA_W-1:0] r_wdata = '0;

    mem_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
    mem_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

    assign bus_a.req_valid = sel_b ? '0 : r_valid;
    assign bus_a.req_we    = r_we;
    assign bus_a.req_addr  = r_addr;
    assign bus_a.req_wdata = r_wdata;
    assign bus_b.req_valid = sel_b ? r_valid : '0;
    assign bus_b.req_we    = r_we;
    assign bus_b.req_addr  = r_addr;
    assign bus_b.req_wdata = r_wdata;

    logic             busy_a, busy_b;
    logic [IDX_W-1:0] gnt_a, gnt_b, ptr_a, ptr_b;
    arb_state_t       st_a, st_b;

    mem_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .busy(busy_a), .gnt_id(gnt_a),
        .dbg_state(st_a), .dbg_rr_ptr(ptr_a)
    );

    mem_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .busy(busy_b), .gnt_id(gnt_b),
        .dbg_state(st_b), .dbg_rr_ptr(ptr_b)
    );

    // ---------------- RAM models ----------------
    // Unwritten words read back as a fixed pattern of their address.
    function automatic logic [DATA_W-1:0] fill(input logic [7:0] a);
        return 32'hC0DE_0000 | {24'h0, a};
    endfunction

    logic [DATA_W-1:0] ram_a [256];
    bit                wr_a  [256];
    logic [DATA_W-1:0] q_a;
    always @(posedge clk) begin
        if (bus_a.mem_wren) begin
            ram_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
            wr_a[bus_a.mem_addr[7:0]]  <= 1'b1;
        end
        q_a <= wr_a[bus_a.mem_addr[7:0]] ? ram_a[bus_a.mem_addr[7:0]] : fill(bus_a.mem_addr[7:0]);
    end
    assign bus_a.mem_q = q_a;

    logic [DATA_W-1:0] ram_b [256];
    bit                wr_b  [256];
    logic [DATA_W-1:0] s1_b, s2_b, q_b;
    always @(posedge clk) begin
        if (bus_b.mem_wren) begin
            ram_b[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
            wr_b[bus_b.mem_addr[7:0]]  <= 1'b1;
        end
        s1_b <= wr_b[bus_b.mem_addr[7:0]] ? ram_b[bus_b.mem_addr[7:0]] : fill(bus_b.mem_addr[7:0]);
        s2_b <= s1_b;
        q_b  <= s2_b;
    end
    assign bus_b.mem_q = q_b;

    // ---------------- selected-DUT observation ----------------
    logic [NREQ-1:0]   ack_s;
    logic [DATA_W-1:0] rdata_s;
    logic              wren_s;
    logic [ADDR_W-1:0] addr_s;
    assign ack_s   = sel_b ? bus_b.req_ack   : bus_a.req_ack;
    assign rdata_s = sel_b ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    assign wren_s  = sel_b ? bus_b.mem_wren  : bus_a.mem_wren;
    assign addr_s  = sel_b ? bus_b.mem_addr  : bus_a.mem_addr;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int i, input bit rd, input logic [DATA_W-1:0] d);
        exp_q.push_back({NREQ'(1) << i, rd, d});
    endfunction

    always @(negedge clk) begin
        if (ack_s != '0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack actual=%b required=none", ack_s);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_vec", ack_s, mon_e[EW-1 -: NREQ]);
                if (mon_e[DATA_W]) check("rsp_rdata", rdata_s, mon_e[DATA_W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        r_valid[i]                  = 1'b1;
        r_we[i]                     = we;
        r_addr[i*ADDR_W +: ADDR_W]  = a;
        r_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        r_valid = '0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_state"},     st_a, IDLE);
        check({tag, "_rr_ptr"},    ptr_a, 0);
        check({tag, "_busy"},      busy_a, 0);
        check({tag, "_gnt_id"},    gnt_a, 0);
        check({tag, "_req_ack"},   bus_a.req_ack, 0);
        check({tag, "_rsp_rdata"}, bus_a.rsp_rdata, 0);
        check({tag, "_mem_addr"},  bus_a.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus_a.mem_wdata, 0);
        check({tag, "_mem_wren"},  bus_a.mem_wren, 0);
    endtask

    // One isolated transaction; negedge k after issue corresponds to cycle E+k-1.
    task automatic single(input string tag, input int i, input logic we,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [DATA_W-1:0] exp_rd, input int exp_ack_at);
        int n, ack_at, wren_at, wren_n;
        logic [ADDR_W-1:0] wren_addr;
        n = 0; ack_at = 0; wren_at = 0; wren_n = 0; wren_addr = '0;
        @(posedge clk); #1;
        push_exp(i, !we, exp_rd);
        set_req(i, we, a, d);
        while (ack_at == 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (wren_s) begin
                wren_n++;
                if (wren_at == 0) begin
                    wren_at   = n;
                    wren_addr = addr_s;
                end
            end
            if (ack_s[i]) ack_at = n;
        end
        @(posedge clk); #1;
        r_valid[i] = 1'b0;
        check({tag, "_ack_cycle"}, ack_at, exp_ack_at);
        check({tag, "_wren_cycles"}, wren_n, we ? 1 : 0);
        if (we) begin
            check({tag, "_wren_at"}, wren_at, 2);
            check({tag, "_wren_addr"}, wren_addr, a);
        end
    endtask

    // ---------------- main sequence ----------------
    int got, acks, guard, n;
    int nxt [NREQ];
    int ack_cyc [4];

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        #1 check_idle_zero("in_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_idle_zero("post_reset");

        // single write then read, READ_LAT=1
        single("wr1", REQ_DATA, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 3);
        single("rd2", REQ_FETCH, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 4);

        // READ_LAT=3 instance
        @(posedge clk); #1 sel_b = 1'b1;
        single("b_wr1", REQ_DATA, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 3);
        single("b_rd2", REQ_FETCH, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 6);
        @(posedge clk); #1 sel_b = 1'b0;

        // all three requesting continuously from reset
        do_reset();
        for (int k = 0; k < 10; k++) begin
            push_exp(0, 1'b0, 32'h0);
            push_exp(1, 1'b1, fill(8'(8'h80 + k)));
            push_exp(2, 1'b1, fill(8'(8'hA0 + k)));
        end
        for (int k = 0; k < NREQ; k++) nxt[k] = 0;
        @(posedge clk); #1;
        set_req(0, 1'b1, 16'h0040, 32'h2000);
        set_req(1, 1'b0, 16'h0080, 32'h0);
        set_req(2, 1'b0, 16'h00A0, 32'h0);
        acks = 0; guard = 0;
        while (acks < 30 && guard < 400) begin
            @(negedge clk);
            guard++;
            got = -1;
            for (int k = 0; k < NREQ; k++) if (ack_s[k]) got = k;
            if (got >= 0) begin
                check("rr_gnt_id", gnt_a, acks % 3);
                acks++;
            end
            @(posedge clk); #1;
            if (got >= 0) begin
                nxt[got]++;
                if (nxt[got] < 10) begin
                    case (got)
                        0:       set_req(0, 1'b1, 16'(16'h0040 + nxt[0]), 32'(32'h2000 + nxt[0]));
                        1:       set_req(1, 1'b0, 16'(16'h0080 + nxt[1]), 32'h0);
                        default: set_req(2, 1'b0, 16'(16'h00A0 + nxt[2]), 32'h0);
                    endcase
                end else begin
                    r_valid[got] = 1'b0;
                end
            end
        end
        check("rr_transactions", acks, 30);

        // lone requester 1, back-to-back writes
        for (int k = 0; k < 4; k++) begin
            push_exp(1, 1'b0, 32'h0);
            ack_cyc[k] = 0;
        end
        @(posedge clk); #1;
        set_req(1, 1'b1, 16'h0000, 32'h1000);
        acks = 0; guard = 0;
        while (acks < 4 && guard < 60) begin
            @(negedge clk);
            guard++;
            got = ack_s[1] ? 1 : 0;
            if (got != 0) begin
                ack_cyc[acks] = cyc;
                acks++;
            end
            @(posedge clk); #1;
            if (got != 0) begin
                if (acks < 4) set_req(1, 1'b1, 16'(acks), 32'(32'h1000 + acks));
                else r_valid[1] = 1'b0;
            end
        end
        check("b2b_acks", acks, 4);
        for (int k = 1; k < 4; k++) check("b2b_spacing", ack_cyc[k] - ack_cyc[k-1], 3);
        for (int k = 0; k < 4; k++) check("b2b_ram", ram_a[k], 32'h1000 + k);

        // reset while a write is in ISSUE
        @(posedge clk); #1;
        set_req(1, 1'b1, 16'h0020, 32'h55AA55AA);
        n = 0;
        while (st_a != ISSUE && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_issue", st_a, ISSUE);
        check("rst_wren_before", bus_a.mem_wren, 1);
        rst_n   = 1'b0;
        r_valid = '0;
        #1 check("rst_wren_async", bus_a.mem_wren, 0);
        repeat (2) @(posedge clk);
        #1 check("rst_ram_untouched", wr_a[8'h20], 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_idle_zero("rst_release");

        // requester 0 drops req_valid while its read waits
        push_exp(0, 1'b1, fill(8'h30));
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0030, 32'h0);
        n = 0;
        while (st_a != WAIT && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("drop_in_wait", st_a, WAIT);
        r_valid[0] = 1'b0;
        n = 0; got = 0;
        while (got == 0 && n < 10) begin
            @(negedge clk);
            n++;
            if (ack_s[0]) got = 1;
        end
        check("drop_acked", got, 1);
        @(posedge clk); #1;
        check("drop_rr_ptr", ptr_a, 1);
        push_exp(2, 1'b0, 32'h0);
        push_exp(0, 1'b0, 32'h0);
        set_req(0, 1'b1, 16'h0050, 32'h3000);
        set_req(2, 1'b1, 16'h0051, 32'h3001);
        acks = 0; guard = 0;
        while (acks < 2 && guard < 30) begin
            @(negedge clk);
            guard++;
            got = -1;
            for (int k = 0; k < NREQ; k++) if (ack_s[k]) got = k;
            if (got >= 0) acks++;
            @(posedge clk); #1;
            if (got >= 0) r_valid[got] = 1'b0;
        end
        check("drop_follow_acks", acks, 2);
        check("drop_ram_50", ram_a[8'h50], 32'h3000);
        check("drop_ram_51", ram_a[8'h51], 32'h3001);

        repeat (4) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data RAM between NREQ requesters, e.g. req 0 = loader/debug, req 1 = CPU data port (LOAD/STORE), req 2 = CPU instruction fetch.
- Round-robin arbitration, one transaction in flight at a time, with a valid/ack handshake per requester.
- Sits between the CPU core and the RAM; it owns the RAM address, data and write-enable pins.

Parameters:
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 16, RAM word-address width
- DATA_W, 32, RAM word width
- READ_LAT, 1, RAM read latency in cycles, from the cycle the address is driven to q valid (1..4)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, per requester
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  packed write data
- req_ack  out  NREQ  one-cycle completion pulse, per requester
- rsp_rdata  out  DATA_W  read data, valid only while the matching req_ack bit is high
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  DATA_W  RAM read data
- busy  out  1  transaction in progress (state != IDLE)
- gnt_id  out  clog2(NREQ)  index of the current or last winner

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; rr_ptr = 0.
  - All outputs are 0: req_ack, rsp_rdata, mem_addr, mem_wdata, mem_wren, busy, gnt_id.
- Handshake:
  - A requester holds req_valid, req_we, req_addr and req_wdata stable until it samples its req_ack high.
  - It deasserts req_valid, or presents a new request, on the cycle after the ack.
  - req_valid dropped before ack is a protocol violation. The latched transaction still completes and still acks.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Latch the winner's index, we, addr and wdata. Update gnt_id. Go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_addr and mem_wdata show the latched values.
  - mem_wren = latched we. This is the only cycle mem_wren may be 1.
  - Write: go to RESP. Read: load wait_cnt = READ_LAT-1 and go to WAIT.
- WAIT:
  - mem_addr is held.
  - When wait_cnt = 0, capture mem_q into rsp_rdata and go to RESP. Otherwise decrement wait_cnt.
- RESP (1 cycle):
  - req_ack[winner] = 1.
  - rsp_rdata holds the captured data on a read and is unchanged on a write.
  - rr_ptr = (winner+1) mod NREQ, wrapping from NREQ-1 to 0. Go to IDLE.
- Latency, counted from request sampled in IDLE at edge E:
  - Write: mem_wren high in cycle E+1; ack in cycle E+2.
  - Read: ack in cycle E+2+READ_LAT.
  - Back-to-back issue interval: write 3 cycles, read 3+READ_LAT cycles.
- Simultaneous requests:
  - Strict round-robin; no requester waits more than NREQ-1 transactions.
  - A lone requester is served back-to-back.
- mem_addr and mem_wdata keep their last values when idle. mem_wren stays 0 outside ISSUE.
- Reset mid-transaction:
  - The transaction is abandoned and no ack is issued.
  - A write caught in ISSUE is aborted the instant rst_n falls, because mem_wren clears asynchronously.
- Req on the winner's own line during RESP: ignored, since arbitration only happens in IDLE.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP} (2 bits).
  - Requester index constants REQ_LOADER = 0, REQ_DATA = 1, REQ_FETCH = 2.
  - Max NREQ = 8.
- Sub-module rr_pick (combinational):
  - Inputs: req vector, pointer. Outputs: any and idx.
  - Implemented as double-width vector rotate plus priority encode.

Test Plan:
- Single write: req1 we=1 addr=0x0010 wdata=0xDEADBEEF → mem_wren high for exactly 1 cycle with mem_addr=0x0010; ack[1] 2 cycles after sample; ack[0] and ack[2] never high.
- Single read, READ_LAT=1 and READ_LAT=3: req2 addr=0x0010 with model RAM returning 0xDEADBEEF → rsp_rdata=0xDEADBEEF with ack[2] at E+3 and E+5 respectively; mem_wren stays 0.
- All three requesting continuously from reset (rr_ptr=0) → grant order 0,1,2,0,1,2; gnt_id follows the same sequence; no starvation over 30 transactions.
- Lone requester 1 issuing 4 back-to-back writes to 0x0000..0x0003 → 4 acks spaced 3 cycles apart; RAM contents match.
- rst_n low during ISSUE of a write to 0x0020 → mem_wren drops immediately; RAM[0x0020] unchanged; no ack; after release: state IDLE, rr_ptr=0, all outputs 0.
- Requester 0 drops req_valid in WAIT → ack[0] still pulses once and the next arbitration proceeds from rr_ptr=1.
